// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: sequential PC generation over a single-outstanding
// request/grant/response imem port, a one-entry stall skid buffer and the IF/ID register.
module instruction_fetch_unit #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(32'h0000_0000),
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = DATA_WIDTH'(32'h0000_0013)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_redirect,
    input  logic [DATA_WIDTH-1:0] i_redirect_pc,
    output logic                  o_imem_req,
    output logic [DATA_WIDTH-1:0] o_imem_addr,
    input  logic                  i_imem_gnt,
    input  logic                  i_imem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_imem_rdata,
    output logic                  o_if_valid,
    output logic [DATA_WIDTH-1:0] o_if_inst,
    output logic [DATA_WIDTH-1:0] o_if_pc
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DROP
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_fetch_pc;
    logic [DATA_WIDTH-1:0] r_pend_pc;
    logic                  r_buf_valid;
    logic [DATA_WIDTH-1:0] r_buf_inst;
    logic [DATA_WIDTH-1:0] r_buf_pc;
    logic                  r_if_valid;
    logic [DATA_WIDTH-1:0] r_if_inst;
    logic [DATA_WIDTH-1:0] r_if_pc;

    logic                  w_req;
    logic                  w_fire;
    logic                  w_deliver;

    assign w_req     = (r_state == ST_REQ) && !r_buf_valid;
    assign w_fire    = w_req && i_imem_gnt;
    // Only a response arriving in WAIT without a same-cycle redirect is kept.
    assign w_deliver = i_imem_rvalid && (r_state == ST_WAIT) && !i_redirect;

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_fetch_pc;
    assign o_if_valid  = r_if_valid;
    assign o_if_inst   = r_if_inst;
    assign o_if_pc     = r_if_pc;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: r_state <= ST_REQ;
                ST_REQ: begin
                    if (w_fire) r_state <= i_redirect ? ST_DROP : ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_imem_rvalid)   r_state <= ST_REQ;
                    else if (i_redirect) r_state <= ST_DROP;
                end
                ST_DROP: begin
                    if (i_imem_rvalid) r_state <= ST_REQ;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
        end else begin
            if (i_redirect)  r_fetch_pc <= i_redirect_pc;
            else if (w_fire) r_fetch_pc <= r_fetch_pc + DATA_WIDTH'(4);
            if (w_fire) r_pend_pc <= r_fetch_pc;
        end
    end

    // Skid buffer catches a response that lands while the pipeline is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_valid <= 1'b0;
            r_buf_inst  <= NOP_INST;
            r_buf_pc    <= '0;
        end else if (i_redirect) begin
            r_buf_valid <= 1'b0;
        end else if (w_deliver && !clk_en) begin
            r_buf_valid <= 1'b1;
            r_buf_inst  <= i_imem_rdata;
            r_buf_pc    <= r_pend_pc;
        end else if (clk_en) begin
            r_buf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= '0;
        end else if (i_redirect) begin
            r_if_valid <= 1'b0;
            r_if_inst  <= NOP_INST;
            r_if_pc    <= '0;
        end else if (clk_en) begin
            if (r_buf_valid) begin
                r_if_valid <= 1'b1;
                r_if_inst  <= r_buf_inst;
                r_if_pc    <= r_buf_pc;
            end else if (w_deliver) begin
                r_if_valid <= 1'b1;
                r_if_inst  <= i_imem_rdata;
                r_if_pc    <= r_pend_pc;
            end else begin
                r_if_valid <= 1'b0;
                r_if_inst  <= NOP_INST;
                r_if_pc    <= '0;
            end
        end
    end

    // A full buffer blocks requests, so the memory can never answer into it.
    a_no_rvalid_into_full_buf: assert property (
        @(posedge clk) disable iff (!rst_n) !(i_imem_rvalid && r_buf_valid)
    );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: transaction-level model with a
// per-cycle compare process, plus directed scenarios with literal expectations.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_a, rst_b;
    logic        clk_en;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        req_a, req_b, valid_a, valid_b;
    logic [31:0] addr_a, addr_b, inst_a, inst_b, pc_a, pc_b;

    bit          sel;
    bit          cmp_en;
    int          lat;
    int          checks;
    int          failures;

    logic        act_rst_n, act_req, act_valid;
    logic [31:0] act_addr, act_inst, act_pc;

    assign act_rst_n = sel ? rst_b   : rst_a;
    assign act_req   = sel ? req_b   : req_a;
    assign act_addr  = sel ? addr_b  : addr_a;
    assign act_valid = sel ? valid_b : valid_a;
    assign act_inst  = sel ? inst_b  : inst_a;
    assign act_pc    = sel ? pc_b    : pc_a;

    instruction_fetch_unit #(
        .DATA_WIDTH(32), .RESET_PC(32'h0000_0000), .NOP_INST(32'h0000_0013)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_a), .clk_en(clk_en),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_imem_req(req_a), .o_imem_addr(addr_a), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_if_valid(valid_a), .o_if_inst(inst_a), .o_if_pc(pc_a)
    );

    instruction_fetch_unit #(
        .DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INST(32'h0000_0013)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b), .clk_en(clk_en),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_imem_req(req_b), .o_imem_addr(addr_b), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_if_valid(valid_b), .o_if_inst(inst_b), .o_if_pc(pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0010_0093;
            32'h0000_0004: return 32'h0020_0113;
            default:       return a ^ 32'hCAFE_0000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Memory: answers each grant after 'lat' cycles with mem_data(addr).
    int          mem_cnt;
    bit          mem_busy;
    logic [31:0] mem_addr;
    always @(posedge clk) begin : mem_p
        bit          g;
        bit          rv;
        logic [31:0] ga;
        g  = act_req && gnt;
        ga = act_addr;
        rv = rvalid;
        #1;
        if (!act_rst_n) begin
            mem_busy = 1'b0;
            rvalid   = 1'b0;
            rdata    = '0;
        end else begin
            if (rv) mem_busy = 1'b0;
            if (g) begin
                mem_busy = 1'b1;
                mem_addr = ga;
                mem_cnt  = lat;
            end
            if (mem_busy && mem_cnt == 1) begin
                rvalid = 1'b1;
                rdata  = mem_data(mem_addr);
            end else begin
                rvalid = 1'b0;
                rdata  = '0;
                if (mem_busy) mem_cnt--;
            end
        end
    end

    // Reference model: outstanding fetch queue, stalled-response queue and IF/ID view.
    typedef struct { logic [31:0] pc; bit drop; } out_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    out_t        oq[$];
    ent_t        hq[$];
    bit          m_started;
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_inst, m_ifpc;

    function automatic bit m_req();
        return m_started && oq.size() == 0 && hq.size() == 0;
    endfunction

    always @(posedge clk or negedge act_rst_n) begin
        if (!act_rst_n) begin
            m_started = 1'b0;
            m_pc      = sel ? 32'hFFFF_FFFC : 32'h0000_0000;
            oq.delete();
            hq.delete();
            m_valid   = 1'b0;
            m_inst    = NOP;
            m_ifpc    = '0;
        end else begin : upd
            bit          granted;
            bit          deliver;
            out_t        o;
            ent_t        e;
            logic [31:0] dpc;
            granted = m_req() && gnt;
            deliver = 1'b0;
            dpc     = '0;
            if (rvalid && oq.size() > 0) begin
                o       = oq.pop_front();
                deliver = !o.drop && !redirect;
                dpc     = o.pc;
            end
            if (redirect && oq.size() > 0) oq[0].drop = 1'b1;
            if (granted) oq.push_back('{m_pc, redirect});
            m_pc      = redirect ? redirect_pc : (granted ? m_pc + 32'd4 : m_pc);
            m_started = 1'b1;
            if (redirect) begin
                hq.delete();
                m_valid = 1'b0; m_inst = NOP; m_ifpc = '0;
            end else if (!clk_en) begin
                if (deliver) hq.push_back('{dpc, rdata});
            end else if (hq.size() > 0) begin
                e = hq.pop_front();
                m_valid = 1'b1; m_inst = e.inst; m_ifpc = e.pc;
            end else if (deliver) begin
                m_valid = 1'b1; m_inst = rdata; m_ifpc = dpc;
            end else begin
                m_valid = 1'b0; m_inst = NOP; m_ifpc = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_req",   32'(act_req),   32'(m_req()));
            check("cmp_addr",  act_addr,       m_pc);
            check("cmp_valid", 32'(act_valid), 32'(m_valid));
            check("cmp_inst",  act_inst,       m_inst);
            check("cmp_pc",    act_pc,         m_ifpc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_req(input string tag, input logic r, input logic [31:0] a);
        check({tag, "_req"},  32'(act_req), 32'(r));
        check({tag, "_addr"}, act_addr,     a);
    endtask

    task automatic exp_if(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p);
        check({tag, "_valid"}, 32'(act_valid), 32'(v));
        check({tag, "_inst"},  act_inst,       i);
        check({tag, "_pc"},    act_pc,         p);
    endtask

    // Leaves the bench at the start of the first cycle with a request (C1).
    task automatic do_reset(input bit s, input int l);
        cmp_en = 1'b0;
        rst_a = 1'b0; rst_b = 1'b0;
        sel = s; lat = l;
        clk_en = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b1;
        step(2);
        cmp_en = 1'b1;
        if (s) rst_b = 1'b1;
        else   rst_a = 1'b1;
        step(1);
    endtask

    initial begin
        checks = 0; failures = 0; cmp_en = 1'b0; sel = 1'b0; lat = 1;
        rst_a = 1'b0; rst_b = 1'b0;
        clk_en = 1'b1; redirect = 1'b0; redirect_pc = '0; gnt = 1'b0;
        step(3);
        exp_req("rst_a", 1'b0, 32'h0);
        exp_if("rst_a", 1'b0, NOP, 32'h0);
        check("rst_b_addr", addr_b, 32'hFFFF_FFFC);
        check("rst_b_req",  32'(req_b), 32'h0);

        // Sequential fetch, zero-wait memory.
        do_reset(1'b0, 1);
        exp_req("t1_c1", 1'b1, 32'h0);
        exp_if("t1_c1", 1'b0, NOP, 32'h0);
        step(1);
        exp_req("t1_c2", 1'b0, 32'h4);
        exp_if("t1_c2", 1'b0, NOP, 32'h0);
        step(1);
        exp_if("t1_c3", 1'b1, 32'h0010_0093, 32'h0);
        exp_req("t1_c3", 1'b1, 32'h4);
        step(1);
        exp_if("t1_c4", 1'b0, NOP, 32'h0);
        step(1);
        exp_if("t1_c5", 1'b1, 32'h0020_0113, 32'h4);
        exp_req("t1_c5", 1'b1, 32'h8);

        // Stall from the grant cycle for three cycles.
        do_reset(1'b0, 1);
        step(2);
        clk_en = 1'b0;
        step(1);
        exp_if("t2_c4", 1'b1, 32'h0010_0093, 32'h0);
        exp_req("t2_c4", 1'b0, 32'h8);
        step(1);
        exp_if("t2_c5", 1'b1, 32'h0010_0093, 32'h0);
        exp_req("t2_c5", 1'b0, 32'h8);
        step(1);
        clk_en = 1'b1;
        exp_if("t2_c6", 1'b1, 32'h0010_0093, 32'h0);
        exp_req("t2_c6", 1'b0, 32'h8);
        step(1);
        exp_if("t2_c7", 1'b1, 32'h0020_0113, 32'h4);
        exp_req("t2_c7", 1'b1, 32'h8);
        step(1);
        exp_if("t2_c8", 1'b0, NOP, 32'h0);

        // Redirect while the fetch of 8 is outstanding (two-cycle memory).
        do_reset(1'b0, 2);
        step(6);
        exp_if("t3_c7", 1'b1, 32'h0020_0113, 32'h4);
        exp_req("t3_c7", 1'b1, 32'h8);
        step(1);
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        step(1);
        redirect = 1'b0;
        exp_if("t3_c9", 1'b0, NOP, 32'h0);
        exp_req("t3_c9", 1'b0, 32'h100);
        step(1);
        exp_if("t3_c10", 1'b0, NOP, 32'h0);
        exp_req("t3_c10", 1'b1, 32'h100);
        step(3);
        exp_if("t3_c13", 1'b1, 32'hCAFE_0100, 32'h100);

        // Redirect in the grant cycle, then redirect combined with a stall.
        do_reset(1'b0, 1);
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        step(1);
        redirect = 1'b0;
        exp_if("t4_c2", 1'b0, NOP, 32'h0);
        exp_req("t4_c2", 1'b0, 32'h200);
        step(1);
        exp_if("t4_c3", 1'b0, NOP, 32'h0);
        exp_req("t4_c3", 1'b1, 32'h200);
        step(2);
        exp_if("t4_c5", 1'b1, 32'hCAFE_0200, 32'h200);
        exp_req("t4_c5", 1'b1, 32'h204);
        redirect = 1'b1; redirect_pc = 32'h0000_0300; clk_en = 1'b0;
        step(1);
        redirect = 1'b0; clk_en = 1'b1;
        exp_if("t4_c6", 1'b0, NOP, 32'h0);
        exp_req("t4_c6", 1'b0, 32'h300);
        step(1);
        exp_if("t4_c7", 1'b0, NOP, 32'h0);
        exp_req("t4_c7", 1'b1, 32'h300);
        step(3);

        // Address wrap with three-cycle memory latency.
        do_reset(1'b1, 3);
        exp_req("t5_c1", 1'b1, 32'hFFFF_FFFC);
        step(1);
        exp_req("t5_c2", 1'b0, 32'h0);
        step(3);
        exp_if("t5_c5", 1'b1, 32'h3501_FFFC, 32'hFFFF_FFFC);
        exp_req("t5_c5", 1'b1, 32'h0);
        step(4);
        exp_if("t5_c9", 1'b1, 32'h0010_0093, 32'h0);

        // Asynchronous reset while a fetch is outstanding.
        do_reset(1'b0, 1);
        step(2);
        clk_en = 1'b0;
        step(1);
        exp_if("t6_c4", 1'b1, 32'h0010_0093, 32'h0);
        #2;
        rst_a = 1'b0;
        #1;
        exp_req("t6_rst", 1'b0, 32'h0);
        exp_if("t6_rst", 1'b0, NOP, 32'h0);
        clk_en = 1'b1;
        step(2);
        rst_a = 1'b1;
        step(1);
        exp_req("t6_c1", 1'b1, 32'h0);
        step(2);
        exp_if("t6_c3", 1'b1, 32'h0010_0093, 32'h0);
        step(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage and IF/ID pipeline register. The block generates sequential PCs, fetches instructions over a single-outstanding request/grant/response instruction-memory port, and presents `o_if_inst`/`o_if_pc` to `instruction_decode`. It honours the same `clk_en` stall and flush semantics as the ID/EX register, and takes branch/jump redirects from EX.

## Interface
- `DATA_WIDTH`, default 32: instruction and address width.
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `NOP_INST`, default 32'h0000_0013: bubble encoding (`addi x0,x0,0`).
- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `clk_en` in 1: pipeline advance. Low = stall, and the IF/ID register holds.
- `i_redirect` in 1: flush plus PC redirect from EX (taken branch/jump). Overrides `clk_en`.
- `i_redirect_pc` in DATA_WIDTH: redirect target. Sampled only when `i_redirect`=1.
- `o_imem_req` out 1: fetch request.
- `o_imem_addr` out DATA_WIDTH: fetch address. Stable while `o_imem_req`=1 and not granted.
- `i_imem_gnt` in 1: request accepted in this cycle.
- `i_imem_rvalid` in 1: response data valid.
- `i_imem_rdata` in DATA_WIDTH: fetched instruction.
- `o_if_valid` out 1: IF/ID holds a real instruction.
- `o_if_inst` out DATA_WIDTH: instruction to ID (`i_if_inst`).
- `o_if_pc` out DATA_WIDTH: PC of `o_if_inst` (`i_if_pc`).

## Operation

**Registers**
- `fetch_pc`: next address to request.
- `pend_pc`: address of the outstanding request.
- One-entry skid buffer: `buf_valid`, `buf_inst`, `buf_pc`.
- FSM `state`.

**Memory port**
- `o_imem_req` = (state==REQ) && !buf_valid.
- `o_imem_addr` = `fetch_pc`.

**FSM states:** IDLE, REQ, WAIT, DROP.
- IDLE (reset state) → REQ unconditionally on the first edge after `rst_n` rises.
- REQ & req & gnt:
  - `pend_pc` ← `fetch_pc`.
  - `fetch_pc` ← `fetch_pc`+4, modulo 2^DATA_WIDTH (wraps from 32'hFFFF_FFFC to 0).
  - Next state is WAIT, or DROP if `i_redirect` is asserted in the same cycle.
- WAIT & rvalid → REQ. The response is delivered (see routing below).
- WAIT & `i_redirect` & !rvalid → DROP.
- WAIT & `i_redirect` & rvalid → REQ, and the response is discarded.
- DROP & rvalid → REQ, and the response is discarded.

**Redirect, any state**
- `fetch_pc` ← `i_redirect_pc`. This overrides the +4 update.
- `buf_valid` ← 0.
- A REQ-state request not granted in the redirect cycle changes address to the new PC on the next cycle; this is a legal retarget.

**Response routing (non-discarded rvalid)**
- `clk_en`=1: load IF/ID directly.
- `clk_en`=0: load the skid buffer (`buf_valid`←1) and suppress new requests.
- rvalid with `buf_valid`=1 cannot occur; flag it with an assertion.

**IF/ID register update**, priority order:
1. `i_redirect` → `o_if_valid`=0, `o_if_inst`=`NOP_INST`, `o_if_pc`=0.
2. `clk_en`=0 → hold.
3. `buf_valid` → load buffer, `buf_valid`←0.
4. Delivered rvalid → load `i_imem_rdata`/`pend_pc`, `o_if_valid`=1.
5. Otherwise bubble: valid=0, `NOP_INST`, pc=0.

## Timing

**Reset values:**
- `o_imem_req`=0, `o_imem_addr`=`RESET_PC`.
- `o_if_valid`=0, `o_if_inst`=`NOP_INST`, `o_if_pc`=0.
- `buf_valid`=0, state=IDLE.

**Reset mid-operation:** asynchronous return to reset values. Any outstanding response after `rst_n` rises is not tracked; the memory is required to be reset together with this block.

**Latency:**
- Grant in cycle N, earliest rvalid in N+1.
- Instruction visible on `o_if_*` after the edge ending N+1.
- First request is asserted in the second cycle after reset release.

**Throughput:** one instruction per 2 cycles with zero-wait memory (REQ, WAIT, REQ, ...).

**Handshakes:**
- `gnt` is ignored when `o_imem_req`=0.
- `rvalid` is ignored in IDLE and REQ.

**Stall release:** buffer data reaches IF/ID on the first `clk_en`=1 edge. `o_imem_req` reasserts in the cycle after.

**Simultaneous events:**
- Redirect with stall: flush wins.
- Redirect with gnt: the grant is consumed, goes to DROP, and its response is discarded.

## Test plan
- **Reset then sequential fetch:** release reset, memory grants immediately, rvalid one cycle later, data 32'h0010_0093/32'h0020_0113. Required response: the first request has addr 0; `o_if_pc`=0 then 4; `o_if_valid` pulses every other cycle.
- **Stall with response in flight:** `clk_en`=0 from the grant cycle for 3 cycles. Required response: the response is buffered, `o_if_*` holds its previous value, no new request is issued; after release the buffered instruction appears, then the request for the next PC.
- **Redirect while in WAIT:** `i_redirect`=1 with `i_redirect_pc`=32'h0000_0100 while a fetch of 8 is outstanding. Required response: `o_if_valid`=0 next cycle, the response for 8 is discarded, the next request has addr 32'h100.
- **Redirect in the same cycle as gnt:** Required response: the granted fetch's rdata never reaches IF/ID; the following request uses the redirect target.
- **Address wrap and variable latency:** `RESET_PC`=32'hFFFF_FFFC, rvalid delayed 3 cycles. Required response: fetches FFFF_FFFC then 0; `o_if_pc` matches.
- **Async reset asserted during WAIT:** Required response: all outputs return to reset values immediately; after release, fetch restarts at `RESET_PC`.
